ma_stage: RTL and testbench

- Memory-access (MA) pipeline stage, directly downstream of the execute stage and upstream of write-back.
- Registers the 71-bit EX→MA bus and takes the synchronous data-SRAM read data, which returns in MA's first cycle.
- Selects the load data or the ALU result as the final result, and forwards {gr_we, dest, result, pc} to WB.
- Holds the SRAM read data stable across WB back-pressure, and exports its destination to ID for hazard detection.

---
 rtl/ma_stage.sv | 60 ++++++
 tb/tb_ma_stage.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/ma_stage.sv
// Memory-access pipeline stage: registers the EX->MA bus, picks load data or ALU result,
// and keeps the SRAM read data stable while write-back stalls.
module ma_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_validout,
  input  logic        wb_allowin,
  output logic        ma_allowin,
  output logic        ma_validout,
  input  logic [70:0] ex_to_ma_bus,
  input  logic [31:0] data_sram_rdata,
  output logic [69:0] ma_to_wb_bus,
  output logic [5:0]  ma_to_id_bus
);

  typedef struct packed {
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } ex_ma_t;

  logic        valid;
  logic        hold_valid;
  logic [31:0] rdata_hold;
  ex_ma_t      bus_r;
  logic        readygo;
  logic [31:0] mem_result;
  logic [31:0] final_result;

  assign readygo     = 1'b1;
  assign ma_allowin  = ~valid | (readygo & wb_allowin);
  assign ma_validout = valid & readygo;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid      <= 1'b0;
      bus_r      <= '0;
      hold_valid <= 1'b0;
      rdata_hold <= '0;
    end else begin
      if (ma_allowin) valid <= ex_validout;
      if (ex_validout & ma_allowin) bus_r <= ex_ma_t'(ex_to_ma_bus);
      // The SRAM output moves on after the first MA cycle, so snapshot it once on a stall.
      if (ma_allowin) begin
        hold_valid <= 1'b0;
      end else if (valid & ~hold_valid) begin
        hold_valid <= 1'b1;
        rdata_hold <= data_sram_rdata;
      end
    end
  end

  assign mem_result   = hold_valid ? rdata_hold : data_sram_rdata;
  assign final_result = bus_r.res_from_mem ? mem_result : bus_r.alu_result;
  assign ma_to_wb_bus = {bus_r.gr_we, bus_r.dest, final_result, bus_r.pc};
  assign ma_to_id_bus = {bus_r.gr_we & valid, bus_r.dest & {5{valid}}};

endmodule

// File: tb/tb_ma_stage.sv
// Scoreboard bench for ma_stage: the stage is modelled as a one-deep buffer holding
// the expected WB payload; a negedge monitor compares whatever the DUT presents.
module tb_ma_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_validout = 1'b0;
  logic        wb_allowin = 1'b0;
  logic        ma_allowin;
  logic        ma_validout;
  logic [70:0] ex_to_ma_bus = '0;
  logic [31:0] data_sram_rdata = '0;
  logic [69:0] ma_to_wb_bus;
  logic [5:0]  ma_to_id_bus;

  int errors = 0;
  int checks = 0;

  logic [69:0] exp_q[$];
  logic        fix_last = 1'b0;

  ma_stage dut (
    .clk(clk), .rst(rst), .ex_validout(ex_validout), .wb_allowin(wb_allowin),
    .ma_allowin(ma_allowin), .ma_validout(ma_validout), .ex_to_ma_bus(ex_to_ma_bus),
    .data_sram_rdata(data_sram_rdata), .ma_to_wb_bus(ma_to_wb_bus), .ma_to_id_bus(ma_to_id_bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [70:0] mk(input logic mem, input logic we, input logic [4:0] d,
                                     input logic [31:0] alu, input logic [31:0] pc);
    return {mem, we, d, alu, pc};
  endfunction

  // Monitor: the held instruction is whatever sits at the head of the expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      logic [69:0] e;
      logic        have;
      have = exp_q.size() > 0;
      chk("validout", 70'(ma_validout), 70'(have));
      chk("allowin", 70'(ma_allowin), 70'(!have || wb_allowin));
      if (have) begin
        e = exp_q[0];
        if (ma_validout) chk("wb_bus", ma_to_wb_bus, e);
        chk("id_bus", 70'(ma_to_id_bus), 70'({e[69], e[68:64]}));
        if (wb_allowin) void'(exp_q.pop_front());
      end else begin
        chk("id_bus_idle", 70'(ma_to_id_bus), 70'd0);
      end
    end
  end

  // One clock: drive inputs, let the edge happen, record what the stage took in.
  task automatic cycle(input logic ev, input logic wa, input logic [70:0] bus, input logic [31:0] rd);
    logic take;
    ex_validout = ev;
    wb_allowin = wa;
    ex_to_ma_bus = bus;
    data_sram_rdata = rd;
    // A load accepted last edge reads the data presented during its first MA cycle.
    if (fix_last) exp_q[$][63:32] = rd;
    fix_last = 1'b0;
    take = ev && (exp_q.size() == 0 || wa);
    @(posedge clk);
    if (take) begin
      exp_q.push_back({bus[69], bus[68:64], bus[63:32], bus[31:0]});
      fix_last = bus[70];
    end
    #1;
  endtask

  task automatic do_reset(input logic ev);
    rst = 1'b1;
    ex_validout = ev;
    wb_allowin = 1'b0;
    @(posedge clk);
    exp_q.delete();
    fix_last = 1'b0;
    #1;
    rst = 1'b0;
    ex_validout = 1'b0;
    chk("rst_validout", 70'(ma_validout), 70'd0);
    chk("rst_allowin", 70'(ma_allowin), 70'd1);
  endtask

  initial begin
    do_reset(1'b0);
    repeat (3) cycle(1'b0, 1'b1, '0, $urandom);
    chk("rst_wb_bus", ma_to_wb_bus, 70'd0);
    chk("rst_id_bus", 70'(ma_to_id_bus), 70'd0);

    // ALU op, then a load that transfers immediately.
    cycle(1'b1, 1'b1, mk(1'b0, 1'b1, 5'd3, 32'h12345678, 32'h1c000010), $urandom);
    cycle(1'b1, 1'b1, mk(1'b1, 1'b1, 5'd7, 32'h00000abc, 32'h1c000014), $urandom);
    cycle(1'b0, 1'b1, '0, 32'hdeadbeef);

    // Load under a 3-cycle WB stall; the accept cycle also takes a new load.
    cycle(1'b1, 1'b1, mk(1'b1, 1'b1, 5'd9, 32'h0, 32'h1c000020), $urandom);
    cycle(1'b0, 1'b0, '0, 32'hcafef00d);
    cycle(1'b1, 1'b0, mk(1'b0, 1'b1, 5'd1, 32'h5, 32'h1c000099), 32'h0);
    cycle(1'b0, 1'b0, '0, 32'h11111111);
    cycle(1'b1, 1'b1, mk(1'b1, 1'b1, 5'd10, 32'h0, 32'h1c000024), 32'h22222222);
    cycle(1'b0, 1'b1, '0, 32'h33333333);

    // Back-to-back stream, then a bubble.
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 1'b1, mk(1'b0, 1'b1, 5'(i + 12), 32'($urandom), 32'h1c000100 + 32'(4 * i)), $urandom);
    cycle(1'b0, 1'b1, '0, $urandom);
    cycle(1'b0, 1'b1, '0, $urandom);

    // Reset while stalled on a load.
    cycle(1'b1, 1'b1, mk(1'b1, 1'b1, 5'd20, 32'h0, 32'h1c000200), $urandom);
    cycle(1'b0, 1'b0, '0, 32'h44444444);
    cycle(1'b0, 1'b0, '0, 32'h55555555);
    do_reset(1'b1);
    cycle(1'b0, 1'b0, '0, $urandom);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset($urandom_range(0, 1) == 1);
      else cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 {$urandom, $urandom, $urandom}, $urandom);
    end
    repeat (3) cycle(1'b0, 1'b1, '0, $urandom);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
